quadport_ram_arbiter: RTL and testbench

- Front-end controller for the 4-port, 512x16 shared data RAM.
- Four requesters (processor cores / DMA), one per RAM port; each uses a valid/ready request interface and receives read responses.
- Resolves same-address hazards between ports each cycle with rotating priority.
- After reset, optionally runs a clear sequence that writes a fixed value to the whole RAM before accepting requests.

---
 rtl/quadport_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_quadport_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quadport_ram_arbiter.sv
// rtl/quadport_ram_arbiter.sv - four-requester front end for a 4-port shared data RAM
//
// Purpose: maps four valid/ready requesters onto the four ports of a shared
// RAM, drops same-address hazards each cycle using a rotating scan order, and
// optionally clears the whole RAM after reset before accepting traffic.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   req_valid/we/addr/wdata  per-requester request, requester i in slice i
//   req_ready                combinational accept, transfer = valid & ready
//   rsp_valid/rsp_rdata      registered read response, one cycle after grant
//   ram_we/re/addr/wdata     RAM port controls, port i serves requester i
//   ram_rdata                RAM read data, registered by the RAM
//   init_done                high while in RUN
//   stall_count              saturating count of cycles with a conflict denial
module quadport_ram_arbiter #(
   parameter int                ADDR_W     = 9,
   parameter int                DATA_W     = 16,
   parameter bit                INIT_CLEAR = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            req_valid,
   input  logic [3:0]            req_we,
   input  logic [4*ADDR_W-1:0]   req_addr,
   input  logic [4*DATA_W-1:0]   req_wdata,
   output logic [3:0]            req_ready,
   output logic [3:0]            rsp_valid,
   output logic [4*DATA_W-1:0]   rsp_rdata,
   output logic [3:0]            ram_we,
   output logic [3:0]            ram_re,
   output logic [4*ADDR_W-1:0]   ram_addr,
   output logic [4*DATA_W-1:0]   ram_wdata,
   input  logic [4*DATA_W-1:0]   ram_rdata,
   output logic                  init_done,
   output logic [15:0]           stall_count
);

   // Four addresses are cleared per cycle, so the counter spans depth/4.
   localparam int CNT_W = ADDR_W - 2;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] clr_cnt;
   logic [1:0]       ptr;
   logic [3:0]       grant;
   logic             denial;
   logic [3:0]       rsp_valid_q;

   // State register plus the datapath registers that follow it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if (INIT_CLEAR) state <= ST_INIT;
         else            state <= ST_RUN;
         clr_cnt     <= '0;
         ptr         <= '0;
         stall_count <= '0;
         rsp_valid_q <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
         if (denial) begin
            ptr <= ptr + 2'd1;
            if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         end
         rsp_valid_q <= grant & ~req_we;
      end
   end

   // Next-state logic: the clear ends after the last group of four addresses.
   always_comb begin
      state_next = state;
      if (state == ST_INIT && (&clr_cnt)) state_next = ST_RUN;
   end

   // Grant scan starting at ptr. A requester is blocked only by requesters
   // already granted earlier in the scan, so read-read sharing stays allowed.
   always_comb begin
      logic [1:0] idx;
      logic       blocked;
      grant   = '0;
      idx     = '0;
      blocked = 1'b0;
      if (state == ST_RUN) begin
         for (int j = 0; j < 4; j++) begin
            idx     = ptr + 2'(j);
            blocked = 1'b0;
            for (int m = 0; m < 4; m++) begin
               if (grant[m] &&
                   req_addr[m*ADDR_W +: ADDR_W] == req_addr[idx*ADDR_W +: ADDR_W] &&
                   (req_we[m] || req_we[idx]))
                  blocked = 1'b1;
            end
            if (req_valid[idx] && !blocked) grant[idx] = 1'b1;
         end
      end
      denial = (state == ST_RUN) && (|(req_valid & ~grant));
   end

   // Output logic. Combinational outputs are forced low while reset_n is
   // asserted so the RAM sees no clear writes during reset.
   always_comb begin
      req_ready = '0;
      ram_we    = '0;
      ram_re    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (reset_n) begin
         if (state == ST_INIT) begin
            ram_we = 4'b1111;
            for (int i = 0; i < 4; i++) begin
               ram_addr[i*ADDR_W +: ADDR_W]  = {clr_cnt, 2'(i)};
               ram_wdata[i*DATA_W +: DATA_W] = INIT_VALUE;
            end
         end else begin
            req_ready = grant;
            ram_we    = grant & req_we;
            ram_re    = grant & ~req_we;
            for (int i = 0; i < 4; i++) begin
               if (grant[i]) begin
                  ram_addr[i*ADDR_W +: ADDR_W]  = req_addr[i*ADDR_W +: ADDR_W];
                  ram_wdata[i*DATA_W +: DATA_W] = req_wdata[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign init_done = reset_n && (state == ST_RUN);
   assign rsp_valid = rsp_valid_q;

   always_comb begin
      rsp_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_q[i]) rsp_rdata[i*DATA_W +: DATA_W] = ram_rdata[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_quadport_ram_arbiter.sv
// tb/tb_quadport_ram_arbiter.sv - self-checking bench for quadport_ram_arbiter
module tb_quadport_ram_arbiter;
   localparam int AW = 9;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [3:0]      req_valid, req_we, req_ready, rsp_valid, ram_we, ram_re;
   logic [4*AW-1:0] req_addr, ram_addr;
   logic [4*DW-1:0] req_wdata, rsp_rdata, ram_wdata, ram_rdata;
   logic            init_done;
   logic [15:0]     stall_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   quadport_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1'b1), .INIT_VALUE(16'h0000)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .init_done(init_done), .stall_count(stall_count)
   );

   // Shared RAM: read data registered one cycle after ram_re.
   logic [DW-1:0] ram_mem [0:511];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_re[i]) ram_rdata[i*DW +: DW] <= ram_mem[ram_addr[i*AW +: AW]];
         if (ram_we[i]) ram_mem[ram_addr[i*AW +: AW]] <= ram_wdata[i*DW +: DW];
      end
   end

   // Reference model state
   int            m_ptr;
   int            m_stall;
   logic [DW-1:0] m_mem [0:511];
   logic [3:0]    m_rsp_v;
   logic [DW-1:0] m_rsp_d [0:3];
   int            wait_cnt [0:3];

   typedef struct {
      logic [3:0]      v;
      logic [3:0]      we;
      logic [4*AW-1:0] a;
      logic [4*DW-1:0] d;
      logic [3:0]      exp_ready;
      int              exp_stall;
   } vec_t;

   vec_t tbl [0:18];

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we,
                               input int a0, input int a1, input int a2, input int a3,
                               input int d0, input int d1, input int d2, input int d3,
                               input logic [3:0] rdy, input int st);
      vec_t r;
      r.v = v;
      r.we = we;
      r.a = {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
      r.d = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
      r.exp_ready = rdy;
      r.exp_stall = st;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_stall = 0;
      m_rsp_v = '0;
      for (int i = 0; i < 4; i++) begin
         m_rsp_d[i] = '0;
         wait_cnt[i] = 0;
      end
      for (int i = 0; i < 512; i++) m_mem[i] = 16'h0000;
   endtask

   // Called at posedge+1 right after reset_n is released: checks the clear walk.
   task automatic init_seq(input string name);
      logic [4*AW-1:0] ea;
      reset_n = 1'b1;
      for (int k = 0; k < 128; k++) begin
         for (int i = 0; i < 4; i++) ea[i*AW +: AW] = 9'(4*k + i);
         #2;
         chk($sformatf("%s.ctl%0d", name, k), {51'd0, ram_we, ram_re, req_ready, init_done}, {51'd0, 4'hF, 4'h0, 4'h0, 1'b0});
         chk($sformatf("%s.addr%0d", name, k), 64'(ram_addr), 64'(ea));
         chk($sformatf("%s.wdata%0d", name, k), ram_wdata, 64'd0);
         @(posedge clk); #1;
      end
      #1;
      chk({name, ".init_done"}, 64'(init_done), 64'd1);
      model_reset();
   endtask

   // One RUN cycle starting at posedge+1. The model applies the scan rule from
   // ptr, tracking granted requesters in a queue.
   task automatic run_cycle(input logic [3:0] v, input logic [3:0] we,
                            input logic [4*AW-1:0] a, input logic [4*DW-1:0] d,
                            input string name, output logic [3:0] rdy);
      logic [3:0]      g, e_we, e_re;
      logic [4*AW-1:0] e_addr;
      logic [4*DW-1:0] e_wdata, e_rd;
      int              granted[$];
      int              p;
      bit              ok;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d;
      g = '0;
      granted = {};
      for (int j = 0; j < 4; j++) begin
         p = (m_ptr + j) % 4;
         ok = v[p];
         foreach (granted[k])
            if (a[granted[k]*AW +: AW] == a[p*AW +: AW] && (we[granted[k]] || we[p])) ok = 1'b0;
         if (ok) begin
            g[p] = 1'b1;
            granted.push_back(p);
         end
      end
      e_addr = '0; e_wdata = '0; e_rd = '0;
      for (int i = 0; i < 4; i++) begin
         e_we[i] = g[i] & we[i];
         e_re[i] = g[i] & ~we[i];
         if (g[i]) begin
            e_addr[i*AW +: AW]  = a[i*AW +: AW];
            e_wdata[i*DW +: DW] = d[i*DW +: DW];
         end
         if (m_rsp_v[i]) e_rd[i*DW +: DW] = m_rsp_d[i];
      end
      #2;
      rdy = req_ready;
      chk({name, ".ready"}, 64'(req_ready), 64'(g));
      chk({name, ".ram_we"}, 64'(ram_we), 64'(e_we));
      chk({name, ".ram_re"}, 64'(ram_re), 64'(e_re));
      chk({name, ".ram_addr"}, 64'(ram_addr), 64'(e_addr));
      chk({name, ".ram_wdata"}, ram_wdata, e_wdata);
      chk({name, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rsp_v));
      chk({name, ".rsp_rdata"}, rsp_rdata, e_rd);
      chk({name, ".init_done"}, 64'(init_done), 64'd1);
      for (int i = 0; i < 4; i++) begin
         m_rsp_v[i] = g[i] & ~we[i];
         m_rsp_d[i] = m_mem[a[i*AW +: AW]];
      end
      for (int i = 0; i < 4; i++)
         if (g[i] && we[i]) m_mem[a[i*AW +: AW]] = d[i*DW +: DW];
      if ((v & ~g) != 4'b0000) begin
         m_ptr = (m_ptr + 1) % 4;
         if (m_stall < 65535) m_stall++;
      end
      @(posedge clk); #1;
      chk({name, ".stall"}, 64'(stall_count), 64'(m_stall));
   endtask

   initial begin
      logic [3:0]      rdy, pv, pwe;
      logic [4*AW-1:0] pa;
      logic [4*DW-1:0] pd;

      for (int i = 0; i < 512; i++) ram_mem[i] = 16'($urandom);
      req_valid = 4'hF; req_we = 4'hF; req_addr = '0; req_wdata = {4{16'hA5A5}};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 64'(req_ready), 64'd0);
      chk("rst.ram_we", 64'(ram_we), 64'd0);
      chk("rst.ram_re_addr", 64'({ram_re, ram_addr}), 64'd0);
      chk("rst.ram_wdata", ram_wdata, 64'd0);
      chk("rst.rsp", {59'd0, rsp_valid, init_done}, 64'd0);
      chk("rst.stall", 64'(stall_count), 64'd0);

      init_seq("clear");

      // Directed vectors
      tbl[0]  = mk(4'hF, 4'h0,   0, 100, 511,   2,   0,  0,  0,   0, 4'hF, 0);
      tbl[1]  = mk(4'hF, 4'hF,   1,   4,   7,  10,   1,  7, 15,  70, 4'hF, 0);
      tbl[2]  = mk(4'hF, 4'h0,   1,   4,   7,  10,   0,  0,  0,   0, 4'hF, 0);
      tbl[3]  = mk(4'h0, 4'h0,   0,   0,   0,   0,   0,  0,  0,   0, 4'h0, 0);
      tbl[4]  = mk(4'b0101, 4'b0101, 5, 0, 5, 0,     9,  0, 35,   0, 4'b0001, 1);
      tbl[5]  = mk(4'b0100, 4'b0100, 0, 0, 5, 0,     0,  0, 35,   0, 4'b0100, 1);
      tbl[6]  = mk(4'b0010, 4'b0000, 0, 5, 0, 0,     0,  0,  0,   0, 4'b0010, 1);
      tbl[7]  = mk(4'h0, 4'h0,   0,   0,   0,   0,   0,  0,  0,   0, 4'h0, 1);
      tbl[8]  = mk(4'hF, 4'h0,   8,   8,   8,   8,   0,  0,  0,   0, 4'hF, 1);
      tbl[9]  = mk(4'h0, 4'h0,   0,   0,   0,   0,   0,  0,  0,   0, 4'h0, 1);
      tbl[10] = mk(4'hF, 4'hF,   3,   3,   3,   3, 100, 101, 102, 103, 4'b0010, 2);
      tbl[11] = mk(4'b1101, 4'hF, 3,  3,   3,   3, 100, 101, 102, 103, 4'b0100, 3);
      tbl[12] = mk(4'b1001, 4'hF, 3,  3,   3,   3, 100, 101, 102, 103, 4'b1000, 4);
      tbl[13] = mk(4'b0001, 4'hF, 3,  3,   3,   3, 100, 101, 102, 103, 4'b0001, 4);
      tbl[14] = mk(4'b1000, 4'h0, 0,  0,   0,   3,   0,  0,  0,   0, 4'b1000, 4);
      tbl[15] = mk(4'b0011, 4'b0010, 511, 511, 0, 0, 0, 16'hBEEF, 0, 0, 4'b0001, 5);
      tbl[16] = mk(4'b0010, 4'b0010, 0, 511, 0, 0,   0, 16'hBEEF, 0, 0, 4'b0010, 5);
      tbl[17] = mk(4'b0100, 4'b0000, 0, 0, 511, 0,   0,  0,  0,   0, 4'b0100, 5);
      tbl[18] = mk(4'h0, 4'h0,   0,   0,   0,   0,   0,  0,  0,   0, 4'h0, 5);

      for (int n = 0; n < 19; n++) begin
         run_cycle(tbl[n].v, tbl[n].we, tbl[n].a, tbl[n].d, $sformatf("vec%0d", n), rdy);
         chk($sformatf("vec%0d.tbl_ready", n), 64'(rdy), 64'(tbl[n].exp_ready));
         chk($sformatf("vec%0d.tbl_stall", n), 64'(stall_count), 64'(tbl[n].exp_stall));
      end

      // Randomized traffic with held requests on a tiny address set
      pv = '0; pwe = '0; pa = '0; pd = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pv[i] && $urandom_range(0, 99) < 60) begin
               pv[i] = 1'b1;
               pwe[i] = 1'($urandom_range(0, 1));
               pa[i*AW +: AW] = 9'($urandom_range(0, 1) * 508 + $urandom_range(0, 3));
               pd[i*DW +: DW] = 16'($urandom);
            end
         end
         run_cycle(pv, pwe, pa, pd, $sformatf("rnd%0d", n), rdy);
         for (int i = 0; i < 4; i++) begin
            if (pv[i]) begin
               if (rdy[i]) begin
                  checks++;
                  if (wait_cnt[i] > 3) begin
                     failures++;
                     $display("FAIL starve port%0d actual_wait=%0d required_max=3", i, wait_cnt[i]);
                  end
                  pv[i] = 1'b0;
                  wait_cnt[i] = 0;
               end else begin
                  wait_cnt[i]++;
               end
            end
         end
      end
      run_cycle(4'h0, 4'h0, '0, '0, "rnd_drain", rdy);

      // Reset while a read response is pending
      run_cycle(4'b0001, 4'h0, {9'd0, 9'd0, 9'd0, 9'd1}, '0, "mid_read", rdy);
      chk("mid.rsp_pending", 64'(rsp_valid), 64'b0001);
      reset_n = 1'b0;
      #1;
      chk("mid.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid.init_done", 64'(init_done), 64'd0);
      chk("mid.stall", 64'(stall_count), 64'd0);
      chk("mid.ram_ctl", 64'({ram_we, ram_re, req_ready}), 64'd0);
      req_valid = 4'hF; req_we = 4'h0;
      @(posedge clk); #1;
      init_seq("reclear");
      run_cycle(4'b0111, 4'h0, {9'd0, 9'd511, 9'd100, 9'd0}, '0, "post_rd", rdy);
      run_cycle(4'h0, 4'h0, '0, '0, "post_idle", rdy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
